stepdown_pwm_deadtime: RTL

STEPDOWN_PWM_DEADTIME -- requirements
Module: stepdown_pwm_deadtime

---
 rtl/stepdown_pwm_deadtime.sv | 122 ++++++++++++
 1 files changed

// File: rtl/stepdown_pwm_deadtime.sv
// Buck converter high/low-side gate sequencer with fixed dead time, minimum on-time
// and blanked cycle-by-cycle current limit. Moore outputs decoded from the state register.
module stepdown_pwm_deadtime #(
  parameter int DT_CYC = 4,
  parameter int MIN_ON = 3,
  parameter int BLANK  = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CELV,
  input  logic       CELG,
  input  logic       SUB,
  input  logic       en,
  input  logic       pwm_req,
  input  logic       ilim,
  output logic       hs_on,
  output logic       ls_on,
  output logic       ilim_flag,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DT_H  = 3'd1,
    HS_ON = 3'd2,
    DT_L  = 3'd3,
    LS_ON = 3'd4
  } state_t;

  localparam logic [3:0] DT_LOAD   = 4'(DT_CYC - 1);
  localparam logic [3:0] MIN_LOAD  = 4'(MIN_ON - 1);
  localparam logic [3:0] BLANK_THR = 4'(MIN_ON - BLANK);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       flag_q, flag_d;
  logic       sat_q, sat_d;
  logic       blanked;
  logic       ilim_trip;
  logic       unused_pwr;

  assign unused_pwr = CELV ^ CELG ^ SUB;

  // sat_q marks HS_ON cycles after the counter has already sat at zero, which
  // keeps the blanking window finite when BLANK equals MIN_ON.
  assign blanked   = (cnt_q >= BLANK_THR) && !sat_q;
  assign ilim_trip = (state_q == HS_ON) && ilim && !blanked;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      flag_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    flag_d  = flag_q;
    sat_d   = (state_q == HS_ON) && (sat_q || (cnt_q == 4'd0));
    if (!en) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      flag_d  = 1'b0;
      sat_d   = 1'b0;
    end else begin
      if (ilim_trip) begin
        flag_d = 1'b1;
      end else if (!pwm_req) begin
        flag_d = 1'b0;
      end
      case (state_q)
        IDLE: begin
          state_d = pwm_req ? DT_H : DT_L;
          cnt_d   = DT_LOAD;
        end
        DT_H: begin
          if (cnt_q == 4'd0) begin
            state_d = HS_ON;
            cnt_d   = MIN_LOAD;
          end
        end
        HS_ON: begin
          if (ilim_trip || (!pwm_req && (cnt_q == 4'd0))) begin
            state_d = DT_L;
            cnt_d   = DT_LOAD;
          end
        end
        DT_L: begin
          if (cnt_q == 4'd0) begin
            state_d = LS_ON;
          end
        end
        LS_ON: begin
          if (pwm_req && !flag_q) begin
            state_d = DT_H;
            cnt_d   = DT_LOAD;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    hs_on     = (state_q == HS_ON);
    ls_on     = (state_q == LS_ON);
    ilim_flag = flag_q;
    state     = state_q;
  end

endmodule
